rx_frame_fifo: RTL
==================

Name: rx_frame_fifo

Overview:
Store-and-forward receive buffer directly downstream of mac_controller's receive interface, in the rx_mac_clk domain. It writes each received frame speculatively into a circular buffer. When the frame's status vector arrives, the block commits the frame if it is good and rolls it back if it is not. Only whole, good frames are presented to the bridge core, over a valid/ready/last byte stream.

Parameters:
ADDR_W, 11, log2 of buffer depth in entries (default 2048 entries x 9 bits: data + last flag)
STAT_TIMEOUT, 16, max cycles from accepted last beat to rx_stat_valid before the frame is dropped
CNT_W, 16, width of the good/drop frame counters

Ports:
rx_mac_clk  in  1  sole clock
reset  in  1  asynchronous, active-low reset
rx_mac_data  in  8  receive byte from MAC
rx_mac_valid  in  1  byte valid; no backpressure possible
rx_mac_last  in  1  final byte of frame, qualified by rx_mac_valid
rx_stat_valid  in  1  one-cycle strobe, status for the current frame
rx_stat_vector  in  27  [15:0] length, [16] fcs_err, [17] phy_err, [18] runt, [19] oversize, [20] bcast, [21] mcast, [26:22] reserved
out_data  out  8  buffered byte
out_valid  out  1  byte available (committed data only)
out_last  out  1  final byte of frame
out_ready  in  1  consumer accepts byte when out_valid & out_ready
frame_good_cnt  out  CNT_W  committed frames, saturating
frame_drop_cnt  out  CNT_W  dropped frames, saturating
overflow  out  1  one-cycle pulse when a frame is dropped because the buffer filled

Behaviour:
- Reset (reset=0, async): all pointers 0, FSM in IDLE, out_valid=0, out_last=0, out_data=0, counters 0, overflow=0.
- Pointers are ADDR_W+1 bits: wr_ptr (speculative), commit_ptr, rd_ptr. full = (wr_ptr - rd_ptr) == 2^ADDR_W.
- FSM states:
  - IDLE: on rx_mac_valid, write the byte at wr_ptr and go to RECV. If the byte also has last set, go straight to WAIT_STAT.
  - RECV: each valid byte is written and wr_ptr increments. On valid & last, write the byte with last=1 and go to WAIT_STAT.
  - DISCARD: entered on a write attempted while full. Set wr_ptr := commit_ptr, pulse overflow, and ignore bytes until valid & last. Then go to WAIT_STAT with the drop flag set.
  - WAIT_STAT: load timer = STAT_TIMEOUT.
    - On rx_stat_valid: if the drop flag is set or any of vector[19:16] is set, set wr_ptr := commit_ptr and increment frame_drop_cnt. Otherwise set commit_ptr := wr_ptr and increment frame_good_cnt. Return to IDLE.
    - On timer expiry: drop as above.
    - A new rx_mac_valid while in WAIT_STAT drops the pending frame, then handles the byte as in IDLE (status lost is treated as bad).
- rx_stat_valid in the same cycle as the last beat is accepted: the decision is made that cycle, including the last byte. rx_stat_valid in IDLE or RECV is ignored.
- Read side is first-word-fall-through:
  - out_valid = (rd_ptr != commit_ptr). out_data/out_last are presented from rd_ptr.
  - On out_valid & out_ready, rd_ptr increments.
  - A committed frame is visible on out_valid the cycle after commit.
  - out_data/out_last hold stable while out_valid & !out_ready.
- Simultaneous read and write in the same cycle is allowed. full is evaluated on pre-cycle pointers, so a freed slot is usable the next cycle.
- Counters saturate at all-ones and never wrap.
- A rollback never moves wr_ptr behind commit_ptr, and the read side never sees uncommitted bytes.
- Reset mid-frame or mid-read discards all buffer contents.

Decomposition:
- Shared package eth_rx_pkg:
  - stat vector bit-index constants: STAT_LEN_LSB/MSB, STAT_FCS_ERR, STAT_PHY_ERR, STAT_RUNT, STAT_OVERSIZE, STAT_BCAST, STAT_MCAST
  - mask STAT_DROP_MASK = bits 19:16
  - FSM state encoding
- One natural sub-module: rx_fifo_ram, a simple dual-port 9-bit x 2^ADDR_W memory with registered write and asynchronous or FWFT read.

Test Plan:
1. Good frame: 64 bytes 0x00..0x3F with last on 0x3F, then rx_stat_valid with vector=27'h40 two cycles later, out_ready=1 -> 64 bytes out in order, out_last only on 0x3F, frame_good_cnt=1, frame_drop_cnt=0.
2. FCS error: same frame with vector bit16=1 -> out_valid never asserts, frame_drop_cnt=1. A following good 60-byte frame emerges intact.
3. Overflow: ADDR_W=6 (64 entries), out_ready=0, send a 40-byte good frame then a 40-byte frame -> overflow pulses once, the first frame is retained, the second is dropped (drop_cnt=1). Raising out_ready yields exactly 40 bytes.
4. Status timeout: last beat with no rx_stat_valid for STAT_TIMEOUT+1 cycles -> frame dropped, drop_cnt=1. A late rx_stat_valid is ignored.
5. Backpressure: good 100-byte frame, out_ready toggling 1,0,0,1,... -> out_data stable while stalled, all 100 bytes delivered once.
6. Async reset asserted mid-receive after 20 bytes of a committed-pending frame -> immediately out_valid=0, counters=0. The next good frame passes normally.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: status-vector field positions, drop mask and the receive FSM
// encoding shared by the receive-side buffer blocks.
package eth_rx_pkg;

  localparam int STAT_W        = 27;

  localparam int STAT_LEN_LSB  = 0;
  localparam int STAT_LEN_MSB  = 15;
  localparam int STAT_FCS_ERR  = 16;
  localparam int STAT_PHY_ERR  = 17;
  localparam int STAT_RUNT     = 18;
  localparam int STAT_OVERSIZE = 19;
  localparam int STAT_BCAST    = 20;
  localparam int STAT_MCAST    = 21;

  localparam logic [STAT_W-1:0] STAT_DROP_MASK = 27'h00F_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RECV      = 2'd1,
    ST_DISCARD   = 2'd2,
    ST_WAIT_STAT = 2'd3
  } rxState_e;

  function automatic logic statIsBad(input logic [STAT_W-1:0] vec);
    return |(vec & STAT_DROP_MASK);
  endfunction

endpackage

// File: rtl/rx_fifo_ram.sv
// rx_fifo_ram: simple dual-port storage for the frame buffer. Writes are
// registered; the read port is combinational so the buffer can present its
// head entry first-word-fall-through.
module rx_fifo_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Store one entry per accepted receive beat.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: store-and-forward receive buffer. Bytes from the MAC are
// written speculatively; the frame status either commits them to the read
// side or rolls the write pointer back. The read side only ever sees whole,
// good frames.
module rx_frame_fifo
  import eth_rx_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int STAT_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic              rx_mac_clk,
  input  logic              reset,
  input  logic [7:0]        rx_mac_data,
  input  logic              rx_mac_valid,
  input  logic              rx_mac_last,
  input  logic              rx_stat_valid,
  input  logic [STAT_W-1:0] rx_stat_vector,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  frame_good_cnt,
  output logic [CNT_W-1:0]  frame_drop_cnt,
  output logic              overflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(STAT_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] DEPTH_P  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STAT_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  rxState_e          state_q, state_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  commitPtr_q, commitPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              dropFlag_q, dropFlag_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  goodCnt_q, goodCnt_d;
  logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;

  logic              statBad;
  logic              goodInc;
  logic              dropInc;
  logic              takeByte;
  logic              lastTaken;
  logic              statUsed;
  logic [PTR_W-1:0]  writeBase;
  logic              ramWe;
  logic [ADDR_W-1:0] ramWaddr;
  logic [8:0]        ramRdata;
  logic              headValid;
  logic              pop;

  assign statBad = statIsBad(rx_stat_vector);

  rx_fifo_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(9)
  ) uRam (
    .clk_i  (rx_mac_clk),
    .we_i   (ramWe),
    .waddr_i(ramWaddr),
    .wdata_i({rx_mac_last, rx_mac_data}),
    .raddr_i(rdPtr_q[ADDR_W-1:0]),
    .rdata_o(ramRdata)
  );

  // Receive FSM: first settle any pending frame waiting on status, then
  // place the incoming beat relative to the resulting pointers, and finally
  // apply a status strobe that coincides with the frame's last beat.
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    commitPtr_d = commitPtr_q;
    timer_d     = timer_q;
    dropFlag_d  = dropFlag_q;
    overflow_d  = 1'b0;
    goodInc     = 1'b0;
    dropInc     = 1'b0;
    ramWe       = 1'b0;
    ramWaddr    = wrPtr_q[ADDR_W-1:0];
    takeByte    = 1'b0;
    lastTaken   = 1'b0;
    statUsed    = 1'b0;
    writeBase   = wrPtr_q;

    case (state_q)
      ST_IDLE, ST_RECV: begin
        takeByte = rx_mac_valid;
      end
      ST_DISCARD: begin
        if (rx_mac_valid && rx_mac_last) begin
          state_d    = ST_WAIT_STAT;
          dropFlag_d = 1'b1;
          timer_d    = TMR_LOAD;
          lastTaken  = 1'b1;
        end
      end
      ST_WAIT_STAT: begin
        if (rx_stat_valid) begin
          statUsed = 1'b1;
          state_d  = ST_IDLE;
          if (dropFlag_q || statBad) begin
            wrPtr_d = commitPtr_q;
            dropInc = 1'b1;
          end else begin
            commitPtr_d = wrPtr_q;
            goodInc     = 1'b1;
          end
        end else if (rx_mac_valid || (timer_q <= TMR_ONE)) begin
          wrPtr_d = commitPtr_q;
          dropInc = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
        writeBase = wrPtr_d;
        takeByte  = rx_mac_valid;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (takeByte) begin
      if ((writeBase - rdPtr_q) == DEPTH_P) begin
        overflow_d = 1'b1;
        wrPtr_d    = commitPtr_d;
        if (rx_mac_last) begin
          state_d    = ST_WAIT_STAT;
          dropFlag_d = 1'b1;
          timer_d    = TMR_LOAD;
          lastTaken  = 1'b1;
        end else begin
          state_d = ST_DISCARD;
        end
      end else begin
        ramWe    = 1'b1;
        ramWaddr = writeBase[ADDR_W-1:0];
        wrPtr_d  = writeBase + 1'b1;
        if (rx_mac_last) begin
          state_d    = ST_WAIT_STAT;
          dropFlag_d = 1'b0;
          timer_d    = TMR_LOAD;
          lastTaken  = 1'b1;
        end else begin
          state_d = ST_RECV;
        end
      end
    end

    if (lastTaken && rx_stat_valid && !statUsed) begin
      state_d = ST_IDLE;
      if (dropFlag_d || statBad) begin
        wrPtr_d = commitPtr_d;
        dropInc = 1'b1;
      end else begin
        commitPtr_d = wrPtr_d;
        goodInc     = 1'b1;
      end
    end
  end

  // Read side: the head entry is shown whenever committed data is waiting,
  // and the read pointer advances on every accepted handshake.
  always_comb begin
    headValid = (rdPtr_q != commitPtr_q);
    pop       = headValid && out_ready;
    rdPtr_d   = rdPtr_q + {{(PTR_W-1){1'b0}}, pop};
  end

  // Frame counters stop at all-ones instead of wrapping.
  always_comb begin
    goodCnt_d = goodCnt_q;
    dropCnt_d = dropCnt_q;
    if (goodInc && (goodCnt_q != CNT_MAX)) begin
      goodCnt_d = goodCnt_q + 1'b1;
    end
    if (dropInc && (dropCnt_q != CNT_MAX)) begin
      dropCnt_d = dropCnt_q + 1'b1;
    end
  end

  // State, pointers, status timer and the overflow pulse; reset empties the
  // buffer by collapsing all three pointers to zero.
  always_ff @(posedge rx_mac_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wrPtr_q     <= '0;
      commitPtr_q <= '0;
      rdPtr_q     <= '0;
      timer_q     <= '0;
      dropFlag_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      commitPtr_q <= commitPtr_d;
      rdPtr_q     <= rdPtr_d;
      timer_q     <= timer_d;
      dropFlag_q  <= dropFlag_d;
      overflow_q  <= overflow_d;
    end
  end

  // Good and dropped frame counters.
  always_ff @(posedge rx_mac_clk or negedge reset) begin
    if (!reset) begin
      goodCnt_q <= '0;
      dropCnt_q <= '0;
    end else begin
      goodCnt_q <= goodCnt_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  assign out_valid      = headValid;
  assign out_data       = headValid ? ramRdata[7:0] : 8'h00;
  assign out_last       = headValid & ramRdata[8];
  assign frame_good_cnt = goodCnt_q;
  assign frame_drop_cnt = dropCnt_q;
  assign overflow       = overflow_q;

endmodule
